// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_pkg
//  Description : Shared types and the combinational instruction decoder for
//                the LC-3 decode stage.
//                - opcode_e   : 4-bit opcode enumeration
//                - reg_idx_t  : 3-bit architectural register index
//                - decoded_t  : decoded control bundle
//                - lc3_decode : instruction word -> decoded_t
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3_pkg;

    localparam int LC3_WIDTH = 16;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t R7_IDX = 3'd7;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RES  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_e;

    // use_sr1/use_sr2 mark which read selects carry a real source operand.
    // R0 is a legal source, so a zero select alone cannot tell "unused".
    typedef struct packed {
        opcode_e                opcode;
        reg_idx_t               dr;
        reg_idx_t               sr1;
        reg_idx_t               sr2;
        logic [LC3_WIDTH-1:0]   imm;
        logic                   use_imm;
        logic                   writes_reg;
        logic                   sets_cc;
        logic                   illegal;
        logic                   use_sr1;
        logic                   use_sr2;
    } decoded_t;

    function automatic decoded_t lc3_decode(input logic [LC3_WIDTH-1:0] instr);
        decoded_t d;
        logic [LC3_WIDTH-1:0] sext5;
        logic [LC3_WIDTH-1:0] sext6;
        logic [LC3_WIDTH-1:0] sext9;
        logic [LC3_WIDTH-1:0] sext11;
        logic [LC3_WIDTH-1:0] zext8;
        sext5  = {{11{instr[4]}},  instr[4:0]};
        sext6  = {{10{instr[5]}},  instr[5:0]};
        sext9  = {{7{instr[8]}},   instr[8:0]};
        sext11 = {{5{instr[10]}},  instr[10:0]};
        zext8  = {8'h00,           instr[7:0]};
        d        = '0;
        d.opcode = opcode_e'(instr[15:12]);
        case (d.opcode)
            OP_ADD, OP_AND: begin
                d.dr         = instr[11:9];
                d.sr1        = instr[8:6];
                d.use_sr1    = 1'b1;
                d.use_imm    = instr[5];
                d.imm        = sext5;
                d.writes_reg = 1'b1;
                d.sets_cc    = 1'b1;
                if (!instr[5]) begin
                    d.sr2     = instr[2:0];
                    d.use_sr2 = 1'b1;
                end
            end
            OP_NOT: begin
                d.dr         = instr[11:9];
                d.sr1        = instr[8:6];
                d.use_sr1    = 1'b1;
                d.writes_reg = 1'b1;
                d.sets_cc    = 1'b1;
            end
            OP_LD, OP_LDI: begin
                d.dr         = instr[11:9];
                d.imm        = sext9;
                d.writes_reg = 1'b1;
                d.sets_cc    = 1'b1;
            end
            OP_LEA: begin
                d.dr         = instr[11:9];
                d.imm        = sext9;
                d.writes_reg = 1'b1;
            end
            OP_LDR: begin
                d.dr         = instr[11:9];
                d.sr1        = instr[8:6];
                d.use_sr1    = 1'b1;
                d.imm        = sext6;
                d.writes_reg = 1'b1;
                d.sets_cc    = 1'b1;
            end
            OP_ST, OP_STI: begin
                d.sr2     = instr[11:9];
                d.use_sr2 = 1'b1;
                d.imm     = sext9;
            end
            OP_STR: begin
                d.sr1     = instr[8:6];
                d.use_sr1 = 1'b1;
                d.sr2     = instr[11:9];
                d.use_sr2 = 1'b1;
                d.imm     = sext6;
            end
            OP_BR: begin
                d.imm = sext9;
            end
            OP_JMP: begin
                d.sr1     = instr[8:6];
                d.use_sr1 = 1'b1;
            end
            OP_JSR: begin
                d.dr         = R7_IDX;
                d.writes_reg = 1'b1;
                if (instr[11]) begin
                    d.imm = sext11;
                end else begin
                    d.sr1     = instr[8:6];
                    d.use_sr1 = 1'b1;
                end
            end
            OP_TRAP: begin
                d.dr         = R7_IDX;
                d.imm        = zext8;
                d.writes_reg = 1'b1;
            end
            default: begin
                // RTI and the reserved opcode: flagged and passed through
                // with no register side effects.
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_scoreboard
//  Description : Pending-write tracker, one busy bit per register.
//                set_en/set_idx     mark a register busy
//                clr_en/clr_idx     retire a register (ignored if not busy)
//                query_mask         registers the incoming instruction uses
//                query_hit          any queried register still busy after
//                                   this cycle's retire is applied
//                busy               current busy vector
//                A same-cycle set and clear of one index leaves it busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_scoreboard #(
    parameter int NREGS = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       set_en,
    input  logic [$clog2(NREGS)-1:0]   set_idx,
    input  logic                       clr_en,
    input  logic [$clog2(NREGS)-1:0]   clr_idx,
    input  logic [NREGS-1:0]           query_mask,
    output logic                       query_hit,
    output logic [NREGS-1:0]           busy
);

    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clear_mask;

    always_comb begin
        set_mask   = '0;
        clear_mask = '0;
        if (set_en) begin
            set_mask[set_idx] = 1'b1;
        end
        if (clr_en) begin
            clear_mask[clr_idx] = 1'b1;
        end
    end

    // Retire first, then set, so a same-cycle set of the same index wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clear_mask) | set_mask;
        end
    end

    // The retiring register is already considered free, so a writeback
    // releases a stall in the same cycle.
    assign query_hit = |(query_mask & busy & ~clear_mask);

endmodule
`default_nettype wire

// File: rtl/lc3_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_decode_stage
//  Description : LC-3 instruction decode stage in front of the register file.
//                Accepts instr/pc on a valid/ready handshake, registers the
//                decoded bundle and the register-file read selects one cycle
//                later, and holds them until execute takes them.
//                Optional macro SCOREBOARD_EN: tracks pending register writes
//                and stalls on RAW/WAW hazards until writeback retires them.
//                Without it there is no hazard stall and wb_* are ignored.
//  Ports       : clock, reset                 clock / sync active-high reset
//                in_valid, in_ready, instr, pc fetch side
//                SR1, SR2                      registered read selects
//                out_valid, out_ready          execute side handshake
//                opcode, dr, imm, pc_q,
//                use_imm, writes_reg, sets_cc,
//                illegal                       decoded bundle
//                wb_valid, wb_dr               writeback retire
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_decode_stage
    import lc3_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  instr,
    input  logic [WIDTH-1:0]  pc,
    output logic [2:0]        SR1,
    output logic [2:0]        SR2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        opcode,
    output logic [2:0]        dr,
    output logic [WIDTH-1:0]  imm,
    output logic [WIDTH-1:0]  pc_q,
    output logic              use_imm,
    output logic              writes_reg,
    output logic              sets_cc,
    output logic              illegal,
    input  logic              wb_valid,
    input  logic [2:0]        wb_dr
);

    decoded_t         dec;
    logic             hazard;
    logic             accept;
    logic             xfer;
    logic [NREGS-1:0] query_mask;

    assign dec = lc3_decode(instr);

    // Registers the incoming instruction depends on: real sources plus the
    // destination (WAW) when it writes.
    always_comb begin
        query_mask = '0;
        if (dec.use_sr1) begin
            query_mask[dec.sr1] = 1'b1;
        end
        if (dec.use_sr2) begin
            query_mask[dec.sr2] = 1'b1;
        end
        if (dec.writes_reg) begin
            query_mask[dec.dr] = 1'b1;
        end
    end

`ifdef SCOREBOARD_EN
    logic [NREGS-1:0] sb_busy;
    logic             unused_sb;

    lc3_scoreboard #(
        .NREGS      (NREGS)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .set_en     (accept & dec.writes_reg),
        .set_idx    (dec.dr),
        .clr_en     (wb_valid),
        .clr_idx    (wb_dr),
        .query_mask (query_mask),
        .query_hit  (hazard),
        .busy       (sb_busy)
    );

    assign unused_sb = ^sb_busy;
`else
    logic unused_wb;

    assign hazard    = 1'b0;
    assign unused_wb = ^{wb_valid, wb_dr, query_mask};
`endif

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            SR1        <= '0;
            SR2        <= '0;
            opcode     <= '0;
            dr         <= '0;
            imm        <= '0;
            pc_q       <= '0;
            use_imm    <= 1'b0;
            writes_reg <= 1'b0;
            sets_cc    <= 1'b0;
            illegal    <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            SR1        <= dec.sr1;
            SR2        <= dec.sr2;
            opcode     <= dec.opcode;
            dr         <= dec.dr;
            imm        <= dec.imm;
            pc_q       <= pc;
            use_imm    <= dec.use_imm;
            writes_reg <= dec.writes_reg;
            sets_cc    <= dec.sets_cc;
            illegal    <= dec.illegal;
        end else if (xfer) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lc3_decode_stage
//  Description : Directed self-checking bench for lc3_decode_stage. Works with
//                and without SCOREBOARD_EN defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [2:0]  SR1;
    logic [2:0]  SR2;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [2:0]  dr;
    logic [15:0] imm;
    logic [15:0] pc_q;
    logic        use_imm;
    logic        writes_reg;
    logic        sets_cc;
    logic        illegal;
    logic        wb_valid;
    logic [2:0]  wb_dr;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    lc3_decode_stage #(
        .WIDTH      (16),
        .NREGS      (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .pc         (pc),
        .SR1        (SR1),
        .SR2        (SR2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .opcode     (opcode),
        .dr         (dr),
        .imm        (imm),
        .pc_q       (pc_q),
        .use_imm    (use_imm),
        .writes_reg (writes_reg),
        .sets_cc    (sets_cc),
        .illegal    (illegal),
        .wb_valid   (wb_valid),
        .wb_dr      (wb_dr)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 16'h0000;
        pc        = 16'h0000;
        wb_valid  = 1'b0;
        wb_dr     = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        check("init_out_valid", 16'(out_valid), 16'd0);
        check("init_in_ready",  16'(in_ready),  16'd1);

        // ADD R1,R1,#3 with immediate operand
        instr    = 16'h1263;
        pc       = 16'h3001;
        in_valid = 1'b1;
        #1;
        check("add_in_ready", 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
        check("add_out_valid",  16'(out_valid),  16'd1);
        check("add_opcode",     16'(opcode),     16'h1);
        check("add_dr",         16'(dr),         16'd1);
        check("add_sr1",        16'(SR1),        16'd1);
        check("add_sr2",        16'(SR2),        16'd0);
        check("add_use_imm",    16'(use_imm),    16'd1);
        check("add_imm",        imm,             16'h0003);
        check("add_writes_reg", 16'(writes_reg), 16'd1);
        check("add_sets_cc",    16'(sets_cc),    16'd1);
        check("add_pc_q",       pc_q,            16'h3001);
        check("add_illegal",    16'(illegal),    16'd0);

        // Backpressure: bundle must hold for 3 cycles with a new offer waiting
        instr    = 16'h27FF;
        pc       = 16'h3002;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready",  16'(in_ready),  16'd0);
            tick();
            check("bp_out_valid", 16'(out_valid), 16'd1);
            check("bp_imm",       imm,            16'h0003);
            check("bp_dr",        16'(dr),        16'd1);
            check("bp_pc_q",      pc_q,           16'h3001);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 16'(in_ready), 16'd1);
        tick();
        // LD R3,#-1 accepted in the same cycle the ADD left
        check("ld_out_valid",  16'(out_valid),  16'd1);
        check("ld_opcode",     16'(opcode),     16'h2);
        check("ld_dr",         16'(dr),         16'd3);
        check("ld_imm",        imm,             16'hFFFF);
        check("ld_sr1",        16'(SR1),        16'd0);
        check("ld_use_imm",    16'(use_imm),    16'd0);
        check("ld_writes_reg", 16'(writes_reg), 16'd1);
        check("ld_sets_cc",    16'(sets_cc),    16'd1);
        check("ld_pc_q",       pc_q,            16'h3002);

        // Reset while a bundle is waiting on execute
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 16'h0000;
        do_reset();
        check("rst_out_valid",  16'(out_valid),  16'd0);
        check("rst_sr1",        16'(SR1),        16'd0);
        check("rst_sr2",        16'(SR2),        16'd0);
        check("rst_dr",         16'(dr),         16'd0);
        check("rst_imm",        imm,             16'h0000);
        check("rst_pc_q",       pc_q,            16'h0000);
        check("rst_opcode",     16'(opcode),     16'h0);
        check("rst_flags",      16'({use_imm, writes_reg, sets_cc, illegal}), 16'h0);
        check("rst_in_ready",   16'(in_ready),   16'd1);

        // RAW: ADD R1,R1,#3 then ADD R2,R1,R1
        out_ready = 1'b1;
        instr     = 16'h1263;
        in_valid  = 1'b1;
        tick();
        instr = 16'h1441;
`ifdef SCOREBOARD_EN
        #1;
        check("raw_stall0", 16'(in_ready), 16'd0);
        tick();
        check("raw_drained", 16'(out_valid), 16'd0);
        check("raw_stall1",  16'(in_ready),  16'd0);
        tick();
        check("raw_stall2",  16'(in_ready),  16'd0);
        wb_valid = 1'b1;
        wb_dr    = 3'd1;
        #1;
        check("raw_release", 16'(in_ready), 16'd1);
        tick();
        wb_valid = 1'b0;
`else
        #1;
        check("raw_b2b_ready", 16'(in_ready), 16'd1);
        tick();
`endif
        in_valid = 1'b0;
        check("raw_out_valid", 16'(out_valid), 16'd1);
        check("raw_dr",        16'(dr),        16'd2);
        check("raw_sr1",       16'(SR1),       16'd1);
        check("raw_sr2",       16'(SR2),       16'd1);
        check("raw_use_imm",   16'(use_imm),   16'd0);

        // Linkage: TRAP x25, then JSR #0 (retiring R7 in the same cycle),
        // then BRnzp #-2
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 16'hF025;
        tick();
        check("trap_opcode",     16'(opcode),     16'hF);
        check("trap_imm",        imm,             16'h0025);
        check("trap_dr",         16'(dr),         16'd7);
        check("trap_writes_reg", 16'(writes_reg), 16'd1);
        check("trap_sets_cc",    16'(sets_cc),    16'd0);
        instr    = 16'h4800;
        wb_valid = 1'b1;
        wb_dr    = 3'd7;
        #1;
        check("jsr_in_ready", 16'(in_ready), 16'd1);
        tick();
        wb_valid = 1'b0;
        check("jsr_opcode",     16'(opcode),     16'h4);
        check("jsr_dr",         16'(dr),         16'd7);
        check("jsr_imm",        imm,             16'h0000);
        check("jsr_writes_reg", 16'(writes_reg), 16'd1);
        check("jsr_sets_cc",    16'(sets_cc),    16'd0);
        instr = 16'h0FFE;
        tick();
        check("br_imm",        imm,             16'hFFFE);
        check("br_writes_reg", 16'(writes_reg), 16'd0);
        check("br_dr",         16'(dr),         16'd0);

        // Reserved opcode, then an instruction touching R0 must not stall
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 16'hD000;
        tick();
        check("ill_illegal",    16'(illegal),    16'd1);
        check("ill_opcode",     16'(opcode),     16'hD);
        check("ill_writes_reg", 16'(writes_reg), 16'd0);
        check("ill_sets_cc",    16'(sets_cc),    16'd0);
        check("ill_out_valid",  16'(out_valid),  16'd1);
        instr = 16'h1000;
        #1;
        check("ill_sb_clean", 16'(in_ready), 16'd1);
        tick();
        check("r0_opcode", 16'(opcode),  16'h1);
        check("r0_legal",  16'(illegal), 16'd0);
        // STR R5,R2,#5
        instr = 16'h7A85;
        tick();
        check("str_sr1",        16'(SR1),        16'd2);
        check("str_sr2",        16'(SR2),        16'd5);
        check("str_imm",        imm,             16'h0005);
        check("str_writes_reg", 16'(writes_reg), 16'd0);
        check("str_dr",         16'(dr),         16'd0);
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", 16'(out_valid), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
